divide_rate_gen: RTL



---
 rtl/divide_rate_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/divide_rate_gen.sv
// rtl/divide_rate_gen.sv - run-time selectable tick and divided-clock generator
// Optional macro PHASE_SYNC_EN adds sync_in for realigning the period to an external event.
module divide_rate_gen #(
  parameter int CNT_W = 32,
  parameter int DIV0  = 6000000,
  parameter int DIV1  = 1200000,
  parameter int DIV2  = 8,
  parameter int DIV3  = 12000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic [1:0]       state_select,
`ifdef PHASE_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             tick,
  output logic             div_clk,
  output logic [1:0]       active_sel,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {IDLE, RUN} mode_t;

  // Divisors below 2 cannot produce a tick and a two-level clock, so clamp them.
  localparam logic [CNT_W-1:0] N0 = (DIV0 < 2) ? CNT_W'(2) : CNT_W'(DIV0);
  localparam logic [CNT_W-1:0] N1 = (DIV1 < 2) ? CNT_W'(2) : CNT_W'(DIV1);
  localparam logic [CNT_W-1:0] N2 = (DIV2 < 2) ? CNT_W'(2) : CNT_W'(DIV2);
  localparam logic [CNT_W-1:0] N3 = (DIV3 < 2) ? CNT_W'(2) : CNT_W'(DIV3);

  mode_t            mode;
  logic             sync_hit;
  logic [CNT_W-1:0] n_div;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d;
  logic             div_d;
  logic [1:0]       sel_d;

  assign mode = cs ? RUN : IDLE;

`ifdef PHASE_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    n_div = N0;
    case (active_sel)
      2'b00: n_div = N0;
      2'b01: n_div = N1;
      2'b10: n_div = N2;
      2'b11: n_div = N3;
      default: n_div = N0;
    endcase
  end

  assign low_len = n_div - (n_div >> 1);
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    cnt_d  = cnt;
    tick_d = 1'b0;
    div_d  = div_clk;
    sel_d  = active_sel;
    case (mode)
      IDLE: begin
        cnt_d = '0;
        div_d = 1'b0;
        sel_d = state_select;
      end
      RUN: begin
        if (sync_hit) begin
          cnt_d = '0;
          div_d = 1'b0;
          sel_d = state_select;
        end else if (cnt == n_div - CNT_W'(1)) begin
          // Period boundary: the only point where a new divisor may take effect.
          cnt_d  = '0;
          tick_d = 1'b1;
          div_d  = 1'b0;
          sel_d  = state_select;
        end else begin
          cnt_d = cnt_inc;
          div_d = (cnt_inc >= low_len);
        end
      end
      default: begin
        cnt_d = '0;
        div_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      tick       <= 1'b0;
      div_clk    <= 1'b0;
      active_sel <= 2'b00;
    end else begin
      cnt        <= cnt_d;
      tick       <= tick_d;
      div_clk    <= div_d;
      active_sel <= sel_d;
    end
  end

endmodule
